wptr_full: RTL and testbench

- Write-domain pointer and full-flag generator for the asynchronous FIFO.
- Consumes the two-flop-synchronised Gray read pointer (wq2_rptr) produced by the read-to-write synchroniser.
- Owns the write binary/Gray pointers, RAM write address/enable, full, almost-full, fill level and a sticky overflow flag.
- Its wptr output feeds the write-to-read synchroniser.

---
 rtl/wptr_full.sv | 69 ++++++
 tb/tb_wptr_full.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// Write-side pointer logic for an asynchronous FIFO. It keeps the binary and Gray write
// pointers and derives full, almost-full, fill level and overflow from the synchronised read pointer.
module wptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic                  wclr_ovf,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_VAL = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_reg;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_gray;

    assign wen        = winc & ~wfull;
    assign waddr      = wbin_reg[ADDR_WIDTH-1:0];
    assign wbin_next  = wbin_reg + PW'(wen);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    assign rbin[PW-1] = wq2_rptr[PW-1];
    generate
        for (genvar gi = PW - 2; gi >= 0; gi--) begin : g_g2b
            assign rbin[gi] = rbin[gi+1] ^ wq2_rptr[gi];
        end
    endgenerate

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_gray  = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    assign level_next = wbin_next - rbin;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_reg     <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin_reg     <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == full_gray);
            walmost_full <= (level_next >= AFULL_VAL);
            wlevel       <= level_next;
            if (winc & wfull)
                woverflow <= 1'b1;
            else if (wclr_ovf)
                woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: directed scenarios plus randomized traffic against
// an occupancy-count model of the FIFO write side.
module tb_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst = 1'b0;
    logic       winc = 1'b0;
    logic       wclr_ovf = 1'b0;
    logic [4:0] wq2_rptr = '0;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int checks = 0;
    int fails  = 0;

    // Model: free-running write/read counts modulo 32, level = difference.
    int m_wb = 0, m_rb = 0, m_level = 0;
    bit m_full = 0, m_af = 0, m_ovf = 0;
    logic wen_seen;

    wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wclr_ovf(wclr_ovf),
        .wq2_rptr(wq2_rptr), .wen(wen), .waddr(waddr), .wptr(wptr),
        .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
        .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic do_reset();
        @(negedge wclk);
        wrst = 1'b1; winc = 1'b0; wclr_ovf = 1'b0; wq2_rptr = '0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
        m_wb = 0; m_rb = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
    endtask

    // Drive one cycle of stimulus, sample wen before the edge, advance the model.
    task automatic step(input bit inc, input bit clr, input int rb);
        int acc;
        @(negedge wclk);
        winc = inc; wclr_ovf = clr; wq2_rptr = gray(rb);
        m_rb = rb % 32;
        #1 wen_seen = wen;
        acc = (inc && !m_full) ? 1 : 0;
        if (inc && m_full) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_wb = (m_wb + acc) % 32;
        m_level = (m_wb - m_rb + 32) % 32;
        m_full = (m_level == 16);
        m_af = (m_level >= 12);
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (wptr !== 5'd0) begin fails++; $display("FAIL reset_wptr: got %b exp 00000", wptr); end
        checks++; if (wfull !== 1'b0) begin fails++; $display("FAIL reset_wfull: got %b exp 0", wfull); end
        checks++; if (wlevel !== 5'd0) begin fails++; $display("FAIL reset_wlevel: got %0d exp 0", wlevel); end
        checks++; if (woverflow !== 1'b0 || walmost_full !== 1'b0) begin fails++; $display("FAIL reset_flags: got ovf=%b af=%b exp 0 0", woverflow, walmost_full); end
        $display("reset done: wptr=%b wlevel=%0d", wptr, wlevel);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 0);
            checks++; if (wen_seen !== 1'b1) begin fails++; $display("FAIL fill_wen[%0d]: got %b exp 1", i, wen_seen); end
            checks++; if (wptr !== gray(m_wb)) begin fails++; $display("FAIL fill_wptr[%0d]: got %b exp %b", i, wptr, gray(m_wb)); end
            checks++; if (wlevel !== 5'(m_level)) begin fails++; $display("FAIL fill_wlevel[%0d]: got %0d exp %0d", i, wlevel, m_level); end
            checks++; if (walmost_full !== m_af || wfull !== m_full) begin fails++; $display("FAIL fill_flags[%0d]: got af=%b full=%b exp af=%b full=%b", i, walmost_full, wfull, m_af, m_full); end
            $display("fill write %0d: wptr=%b wlevel=%0d af=%b full=%b", i + 1, wptr, wlevel, walmost_full, wfull);
        end
        checks++; if (wptr !== 5'b11000 || wfull !== 1'b1 || wlevel !== 5'd16) begin fails++; $display("FAIL fill_final: got wptr=%b full=%b lvl=%0d exp 11000 1 16", wptr, wfull, wlevel); end
        checks++; if (waddr !== 4'd0) begin fails++; $display("FAIL fill_waddr: got %0d exp 0", waddr); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 0);
            checks++; if (wen_seen !== 1'b0) begin fails++; $display("FAIL ovf_wen[%0d]: got %b exp 0", i, wen_seen); end
            checks++; if (wptr !== 5'b11000) begin fails++; $display("FAIL ovf_wptr[%0d]: got %b exp 11000", i, wptr); end
            checks++; if (woverflow !== 1'b1) begin fails++; $display("FAIL ovf_set[%0d]: got %b exp 1", i, woverflow); end
            $display("write while full %0d: wen=%b wptr=%b ovf=%b", i, wen_seen, wptr, woverflow);
        end
        step(1'b0, 1'b0, 0);
        checks++; if (woverflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b exp 1", woverflow); end
        step(1'b0, 1'b1, 0);
        checks++; if (woverflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b exp 0", woverflow); end
        $display("overflow cleared: ovf=%b", woverflow);
    endtask

    task automatic test_read_release();
        step(1'b0, 1'b0, 1);
        checks++; if (wfull !== 1'b0 || wlevel !== 5'd15) begin fails++; $display("FAIL release: got full=%b lvl=%0d exp 0 15", wfull, wlevel); end
        step(1'b1, 1'b0, 1);
        checks++; if (wfull !== 1'b1 || wptr !== 5'b11001) begin fails++; $display("FAIL refill: got full=%b wptr=%b exp 1 11001", wfull, wptr); end
        $display("read then write: full=%b wptr=%b", wfull, wptr);
    endtask

    task automatic test_wrap();
        int wrapped = 0;
        step(1'b0, 1'b0, (m_wb - 3 + 32) % 32);
        for (int i = 0; i < 40; i++) begin
            if (m_wb == 31) wrapped = 1;
            step(1'b1, 1'b0, (m_wb + 1 - 3 + 32) % 32);
            checks++; if (wfull !== 1'b0 || walmost_full !== 1'b0 || wlevel !== 5'd3) begin fails++; $display("FAIL wrap[%0d]: got full=%b af=%b lvl=%0d exp 0 0 3", i, wfull, walmost_full, wlevel); end
            checks++; if (wptr !== gray(m_wb)) begin fails++; $display("FAIL wrap_wptr[%0d]: got %b exp %b", i, wptr, gray(m_wb)); end
        end
        checks++; if (wrapped !== 1) begin fails++; $display("FAIL wrap_crossed: got %0d exp 1", wrapped); end
        $display("wrap done: wptr=%b wlevel=%0d", wptr, wlevel);
    endtask

    task automatic test_set_wins();
        int rb;
        rb = m_rb;
        for (int i = 0; i < 20 && !m_full; i++) step(1'b1, 1'b0, rb);
        checks++; if (wfull !== 1'b1) begin fails++; $display("FAIL setwins_full: got %b exp 1", wfull); end
        step(1'b1, 1'b1, rb);
        checks++; if (woverflow !== 1'b1 || wen_seen !== 1'b0) begin fails++; $display("FAIL setwins: got ovf=%b wen=%b exp 1 0", woverflow, wen_seen); end
        $display("set vs clear: ovf=%b", woverflow);
        step(1'b0, 1'b1, rb);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int rb;
            rb = (m_rb + $urandom_range(0, m_level)) % 32;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rb);
            checks++;
            if (wptr !== gray(m_wb) || wlevel !== 5'(m_level) || wfull !== m_full ||
                walmost_full !== m_af || woverflow !== m_ovf || waddr !== 4'(m_wb)) begin
                fails++;
                $display("FAIL random[%0d]: got wptr=%b lvl=%0d full=%b af=%b ovf=%b waddr=%0d exp %b %0d %b %b %b %0d",
                         i, wptr, wlevel, wfull, walmost_full, woverflow, waddr,
                         gray(m_wb), m_level, m_full, m_af, m_ovf, m_wb % 16);
            end
            $display("random %0d: winc=%b rptr=%0d wptr=%b lvl=%0d full=%b ovf=%b", i, winc, rb, wptr, wlevel, wfull, woverflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 0);
        checks++; if (wlevel !== 5'd7) begin fails++; $display("FAIL prereset_level: got %0d exp 7", wlevel); end
        @(negedge wclk);
        winc = 1'b0;
        #2 wrst = 1'b1;
        #1;
        checks++; if (wptr !== 5'd0 || wlevel !== 5'd0 || wfull !== 1'b0 || woverflow !== 1'b0) begin fails++; $display("FAIL async_reset: got wptr=%b lvl=%0d full=%b ovf=%b exp all 0", wptr, wlevel, wfull, woverflow); end
        $display("async reset: wptr=%b wlevel=%0d", wptr, wlevel);
        @(negedge wclk);
        wrst = 1'b0;
        m_wb = 0; m_rb = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
        #1;
        checks++; if (waddr !== 4'd0) begin fails++; $display("FAIL post_reset_waddr0: got %0d exp 0", waddr); end
        step(1'b1, 1'b0, 0);
        checks++; if (waddr !== 4'd1 || wptr !== 5'b00001) begin fails++; $display("FAIL post_reset_write: got waddr=%0d wptr=%b exp 1 00001", waddr, wptr); end
        $display("first write after reset: waddr=%0d wptr=%b", waddr, wptr);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_wrap();
        test_set_wins();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
